// File: rtl/msx_slot_mapper.sv
// msx_slot_mapper: MSX primary/secondary slot decode plus four-page memory mapper.
// Define MSX_MAPPER_READBACK_EN to make mapper ports FC..FF readable.
module msx_slot_mapper #(
  parameter logic [3:0] EXP_MASK = 4'b1000,
  parameter int         SEG_BITS = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [15:0]          addr_i,
  input  logic [7:0]           data_i,
  input  logic                 mreq_n_i,
  input  logic                 iorq_n_i,
  input  logic                 rd_n_i,
  input  logic                 wr_n_i,
  input  logic                 m1_n_i,
  input  logic                 rfsh_n_i,
  input  logic [7:0]           ppi_a_i,
  output logic [7:0]           data_o,
  output logic                 data_oe_o,
  output logic [3:0]           sltsl_n_o,
  output logic [15:0]          subsltsl_n_o,
  output logic [SEG_BITS+13:0] ram_addr_o
);
  logic [1:0]          w_page, w_slot, w_sub_sel;
  logic                w_mem, w_io, w_port, w_ffff, w_exp;
  logic                w_strobe, w_sub_wr, w_sub_rd, w_seg_wr;
  logic                r_wr_low;
  logic [7:0]          r_sub [4];
  logic [SEG_BITS-1:0] r_seg [4];

  assign w_page    = addr_i[15:14];
  assign w_slot    = ppi_a_i[{w_page, 1'b0} +: 2];
  assign w_mem     = !mreq_n_i && rfsh_n_i;
  // IO decode requires MREQ high so a memory and an IO write can never coincide
  assign w_io      = !iorq_n_i && m1_n_i && mreq_n_i;
  assign w_port    = w_io && (addr_i[7:2] == 6'h3F);
  assign w_ffff    = addr_i == 16'hFFFF;
  assign w_exp     = EXP_MASK[w_slot];
  // r_wr_low starts at 1 so a write already in progress at reset release is ignored
  assign w_strobe  = !r_wr_low && !wr_n_i;
  assign w_sub_wr  = w_strobe && w_mem && w_ffff && w_exp;
  assign w_sub_rd  = w_mem && !rd_n_i && w_ffff && w_exp;
  assign w_seg_wr  = w_strobe && w_port;
  assign w_sub_sel = r_sub[w_slot][{w_page, 1'b0} +: 2];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wr_low <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        r_sub[i] <= 8'h00;
        r_seg[i] <= SEG_BITS'(3 - i);
      end
    end else begin
      r_wr_low <= !wr_n_i;
      if (w_sub_wr) r_sub[w_slot] <= data_i;
      if (w_seg_wr) r_seg[addr_i[1:0]] <= data_i[SEG_BITS-1:0];
    end
  end

  assign sltsl_n_o    = w_mem ? ~(4'b0001 << w_slot) : 4'hF;
  assign subsltsl_n_o = (w_mem && w_exp && !w_sub_rd) ? ~(16'h0001 << {w_slot, w_sub_sel}) : 16'hFFFF;
  assign ram_addr_o   = {r_seg[w_page], addr_i[13:0]};

`ifdef MSX_MAPPER_READBACK_EN
  logic w_seg_rd;
  assign w_seg_rd  = w_port && !rd_n_i;
  assign data_o    = w_sub_rd ? ~r_sub[w_slot] :
                     w_seg_rd ? (~(8'hFF >> (8 - SEG_BITS)) | 8'(r_seg[addr_i[1:0]])) : 8'hFF;
  assign data_oe_o = w_sub_rd || w_seg_rd;
`else
  assign data_o    = w_sub_rd ? ~r_sub[w_slot] : 8'hFF;
  assign data_oe_o = w_sub_rd;
`endif
endmodule

// File: tb/tb_msx_slot_mapper.sv
// tb_msx_slot_mapper: table, directed and randomized checks against a behavioural slot/mapper model.
module tb_msx_slot_mapper;
  localparam logic [3:0] MASK = 4'b1000;

  logic clk_i = 1'b0;
  logic reset_n_i, mreq_n_i, iorq_n_i, rd_n_i, wr_n_i, m1_n_i, rfsh_n_i;
  logic [15:0] addr_i;
  logic [7:0]  data_i, ppi_a_i;
  logic [7:0]  data_o, b_data_o;
  logic        data_oe_o, b_data_oe_o;
  logic [3:0]  sltsl_n_o, b_sltsl_n_o;
  logic [15:0] subsltsl_n_o, b_subsltsl_n_o;
  logic [17:0] ram_addr_o, b_ram_addr_o;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_sub [4];
  int         m_seg [4];
  logic       m_prev_wr_n;

  always #5 clk_i = ~clk_i;

  msx_slot_mapper #(.EXP_MASK(MASK), .SEG_BITS(4)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .addr_i(addr_i), .data_i(data_i),
    .mreq_n_i(mreq_n_i), .iorq_n_i(iorq_n_i), .rd_n_i(rd_n_i), .wr_n_i(wr_n_i),
    .m1_n_i(m1_n_i), .rfsh_n_i(rfsh_n_i), .ppi_a_i(ppi_a_i),
    .data_o(data_o), .data_oe_o(data_oe_o), .sltsl_n_o(sltsl_n_o),
    .subsltsl_n_o(subsltsl_n_o), .ram_addr_o(ram_addr_o));

  msx_slot_mapper #(.EXP_MASK(4'b0000), .SEG_BITS(4)) dut_b (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .addr_i(addr_i), .data_i(data_i),
    .mreq_n_i(mreq_n_i), .iorq_n_i(iorq_n_i), .rd_n_i(rd_n_i), .wr_n_i(wr_n_i),
    .m1_n_i(m1_n_i), .rfsh_n_i(rfsh_n_i), .ppi_a_i(ppi_a_i),
    .data_o(b_data_o), .data_oe_o(b_data_oe_o), .sltsl_n_o(b_sltsl_n_o),
    .subsltsl_n_o(b_subsltsl_n_o), .ram_addr_o(b_ram_addr_o));

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  ppi;
    logic        mreq_n, iorq_n, rd_n, m1_n, rfsh_n;
    logic [3:0]  sl;
    logic [15:0] sub;
    logic [17:0] ram;
    logic [7:0]  dat;
    logic        oe;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_sub[i] = 8'h00;
      m_seg[i] = (3 - i) % 16;
    end
    m_prev_wr_n = 1'b0;
  endtask

  task automatic set_bus(input logic [15:0] a, input logic mq, input logic io, input logic rd, input logic wr);
    addr_i = a; mreq_n_i = mq; iorq_n_i = io; rd_n_i = rd; wr_n_i = wr; m1_n_i = 1'b1; rfsh_n_i = 1'b1;
  endtask

  // Apply one clock: the model sees a write only on a high-to-low step of wr_n.
  task automatic tick();
    int page, slot;
    page = int'(addr_i) / 16384;
    slot = (int'(ppi_a_i) >> (2 * page)) % 4;
    if (m_prev_wr_n && !wr_n_i) begin
      if (!mreq_n_i && rfsh_n_i && addr_i == 16'hFFFF && MASK[slot])
        m_sub[slot] = data_i;
      else if (!iorq_n_i && m1_n_i && mreq_n_i && addr_i[7:0] >= 8'hFC)
        m_seg[int'(addr_i[7:0]) - 252] = int'(data_i) % 16;
    end
    m_prev_wr_n = wr_n_i;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_all(input string tag);
    int page, slot, idx;
    logic mem, rdreg, io_rd;
    logic [3:0] e_sl;
    logic [15:0] e_sub;
    logic [7:0] e_dat;
    logic e_oe;
    page  = int'(addr_i) / 16384;
    slot  = (int'(ppi_a_i) >> (2 * page)) % 4;
    mem   = !mreq_n_i && rfsh_n_i;
    rdreg = mem && !rd_n_i && addr_i == 16'hFFFF && MASK[slot];
    io_rd = !iorq_n_i && m1_n_i && mreq_n_i && !rd_n_i && addr_i[7:0] >= 8'hFC;
    e_sl  = mem ? (4'hF ^ (4'h1 << slot)) : 4'hF;
    idx   = 4 * slot + ((int'(m_sub[slot]) >> (2 * page)) % 4);
    e_sub = (mem && MASK[slot] && !rdreg) ? (16'hFFFF ^ (16'h1 << idx)) : 16'hFFFF;
    e_dat = 8'hFF;
    e_oe  = 1'b0;
    if (rdreg) begin
      e_dat = ~m_sub[slot];
      e_oe  = 1'b1;
    end
`ifdef MSX_MAPPER_READBACK_EN
    else if (io_rd) begin
      e_dat = 8'hF0 | 8'(m_seg[int'(addr_i[7:0]) - 252]);
      e_oe  = 1'b1;
    end
`else
    if (io_rd) e_oe = 1'b0;
`endif
    chk({tag, ".sltsl"}, 32'(sltsl_n_o), 32'(e_sl));
    chk({tag, ".subsltsl"}, 32'(subsltsl_n_o), 32'(e_sub));
    chk({tag, ".ram_addr"}, 32'(ram_addr_o), 32'(m_seg[page] * 16384 + int'(addr_i) % 16384));
    chk({tag, ".data"}, 32'(data_o), 32'(e_dat));
    chk({tag, ".oe"}, 32'(data_oe_o), 32'(e_oe));
  endtask

  vec_t tbl [10];

  initial begin
    logic [7:0] rb_dat;
    logic rb_oe;
`ifdef MSX_MAPPER_READBACK_EN
    rb_dat = 8'hF1; rb_oe = 1'b1;
`else
    rb_dat = 8'hFF; rb_oe = 1'b0;
`endif
    tbl[0] = '{16'h8000, 8'hFF, 0, 1, 0, 1, 1, 4'h7, 16'hEFFF, 18'h04000, 8'hFF, 0};
    tbl[1] = '{16'h0000, 8'h00, 0, 1, 0, 1, 1, 4'hE, 16'hFFFF, 18'h0C000, 8'hFF, 0};
    tbl[2] = '{16'h4123, 8'h04, 0, 1, 0, 1, 1, 4'hD, 16'hFFFF, 18'h08123, 8'hFF, 0};
    tbl[3] = '{16'hC000, 8'h80, 0, 1, 0, 1, 1, 4'hB, 16'hFFFF, 18'h00000, 8'hFF, 0};
    tbl[4] = '{16'h8000, 8'hFF, 1, 1, 1, 1, 1, 4'hF, 16'hFFFF, 18'h04000, 8'hFF, 0};
    tbl[5] = '{16'h8000, 8'hFF, 0, 1, 1, 1, 0, 4'hF, 16'hFFFF, 18'h04000, 8'hFF, 0};
    tbl[6] = '{16'hFFFF, 8'hC0, 0, 1, 0, 1, 1, 4'h7, 16'hFFFF, 18'h03FFF, 8'hFF, 1};
    tbl[7] = '{16'hFFFF, 8'h00, 0, 1, 0, 1, 1, 4'hE, 16'hFFFF, 18'h03FFF, 8'hFF, 0};
    tbl[8] = '{16'h00FE, 8'h00, 1, 0, 0, 1, 1, 4'hF, 16'hFFFF, 18'h0C0FE, rb_dat, rb_oe};
    tbl[9] = '{16'h00FE, 8'h00, 1, 0, 0, 0, 1, 4'hF, 16'hFFFF, 18'h0C0FE, 8'hFF, 0};

    reset_n_i = 1'b0;
    data_i = 8'h00; ppi_a_i = 8'hFF;
    set_bus(16'h8000, 1, 1, 1, 1);
    model_reset();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    tick();

    set_bus(16'h8000, 0, 1, 0, 1);
    #1;
    chk("reset.ram_addr", 32'(ram_addr_o), 32'h04000);
    chk("reset.sltsl", 32'(sltsl_n_o), 32'h7);
    chk("reset.sub12", 32'(subsltsl_n_o[12]), 32'h0);

    for (int i = 0; i < 10; i++) begin
      addr_i = tbl[i].addr; ppi_a_i = tbl[i].ppi; mreq_n_i = tbl[i].mreq_n;
      iorq_n_i = tbl[i].iorq_n; rd_n_i = tbl[i].rd_n; m1_n_i = tbl[i].m1_n;
      rfsh_n_i = tbl[i].rfsh_n; wr_n_i = 1'b1;
      #1;
      chk($sformatf("tbl%0d.sltsl", i), 32'(sltsl_n_o), 32'(tbl[i].sl));
      chk($sformatf("tbl%0d.subsltsl", i), 32'(subsltsl_n_o), 32'(tbl[i].sub));
      chk($sformatf("tbl%0d.ram_addr", i), 32'(ram_addr_o), 32'(tbl[i].ram));
      chk($sformatf("tbl%0d.data", i), 32'(data_o), 32'(tbl[i].dat));
      chk($sformatf("tbl%0d.oe", i), 32'(data_oe_o), 32'(tbl[i].oe));
    end
    set_bus(16'h0000, 1, 1, 1, 1);
    tick();

    // Subslot write held low four cycles; data changes mid-hold must not load again.
    ppi_a_i = 8'hC0; data_i = 8'h1B;
    set_bus(16'hFFFF, 0, 1, 1, 0);
    tick();
    data_i = 8'h55;
    repeat (3) tick();
    wr_n_i = 1'b1;
    tick();
    rd_n_i = 1'b0;
    #1;
    chk("sub_rd.data", 32'(data_o), 32'hE4);
    chk("sub_rd.oe", 32'(data_oe_o), 32'h1);
    chk("sub_rd.subsltsl", 32'(subsltsl_n_o), 32'hFFFF);
    check_all("sub_rd");

    ppi_a_i = 8'hFC; addr_i = 16'h4000;
    #1;
    chk("page1.sltsl3", 32'(sltsl_n_o[3]), 32'h0);
    chk("page1.subsltsl", 32'(subsltsl_n_o), 32'hBFFF);
    set_bus(16'h0000, 1, 1, 1, 1);
    tick();

    // Mapper write then use and readback.
    data_i = 8'h27;
    set_bus(16'h00FE, 1, 0, 1, 0);
    tick(); tick();
    wr_n_i = 1'b1;
    tick();
    set_bus(16'h8123, 0, 1, 0, 1);
    #1;
    chk("map.ram_addr", 32'(ram_addr_o), 32'h1C123);
    set_bus(16'h00FE, 1, 0, 0, 1);
    #1;
`ifdef MSX_MAPPER_READBACK_EN
    chk("map_rb.data", 32'(data_o), 32'hF7);
    chk("map_rb.oe", 32'(data_oe_o), 32'h1);
`else
    chk("map_rb.oe", 32'(data_oe_o), 32'h0);
    chk("map_rb.data", 32'(data_o), 32'hFF);
`endif
    set_bus(16'h0000, 1, 1, 1, 1);
    tick();

    // FFFF in a non-expanded slot: dut_b has no subslot registers at all.
    ppi_a_i = 8'hC0; data_i = 8'h5A;
    set_bus(16'hFFFF, 0, 1, 1, 0);
    tick();
    wr_n_i = 1'b1;
    tick();
    rd_n_i = 1'b0;
    #1;
    chk("noexp.oe", 32'(b_data_oe_o), 32'h0);
    chk("noexp.data", 32'(b_data_o), 32'hFF);
    chk("noexp.subsltsl", 32'(b_subsltsl_n_o), 32'hFFFF);
    chk("noexp.ram_addr", 32'(b_ram_addr_o), 32'h03FFF);
    check_all("exp_a");
    ppi_a_i = 8'h00; data_i = 8'h77;
    set_bus(16'hFFFF, 0, 1, 1, 0);
    tick();
    wr_n_i = 1'b1;
    tick();
    ppi_a_i = 8'hC0; rd_n_i = 1'b0;
    #1;
    chk("slot0_write.data", 32'(data_o), 32'hA5);
    check_all("slot0_write");

    // Reset asserted during a held FFFF write; no update after release while wr_n stays low.
    rd_n_i = 1'b1; data_i = 8'h3C; wr_n_i = 1'b0;
    tick();
    #2;
    reset_n_i = 1'b0;
    model_reset();
    #1;
    check_all("rst_mid");
    chk("rst_mid.subsltsl", 32'(subsltsl_n_o), 32'hEFFF);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    repeat (3) tick();
    rd_n_i = 1'b0;
    #1;
    chk("rst_rel.data", 32'(data_o), 32'hFF);
    chk("rst_rel.oe", 32'(data_oe_o), 32'h1);
    check_all("rst_rel");
    set_bus(16'h0000, 1, 1, 1, 1);
    tick();

    for (int n = 0; n < 400; n++) begin
      int kind, asel;
      kind = $urandom_range(0, 3);
      asel = $urandom_range(0, 3);
      addr_i   = asel == 0 ? 16'hFFFF : asel == 1 ? {8'($urandom), 8'($urandom_range(252, 255))} : 16'($urandom);
      data_i   = 8'($urandom);
      ppi_a_i  = 8'($urandom);
      rd_n_i   = 1'($urandom_range(0, 1));
      wr_n_i   = 1'($urandom_range(0, 1));
      rfsh_n_i = 1'b1;
      mreq_n_i = kind != 0;
      iorq_n_i = !(kind == 1 || kind == 2);
      m1_n_i   = kind != 2;
      if (kind == 0 && $urandom_range(0, 7) == 0) rfsh_n_i = 1'b0;
      tick();
      check_all($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
